// File: rtl/calc_mvd_cost_multi.sv
// Sequential MVD cost unit: scans up to NUM_CAND predictor candidates, one per cycle, and returns the cheapest.
// Optional ZERO_MVD_EARLY_EXIT_EN stops the scan at the first candidate that matches the MV exactly.
module calc_mvd_cost_multi #(
  parameter int NUM_CAND = 4,
  parameter int MV_W     = 16,
  parameter int FRAC_W   = 64
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ap_start,
  output logic                         ap_done,
  output logic                         ap_idle,
  output logic                         ap_ready,
  input  logic [31:0]                  x,
  input  logic [31:0]                  y,
  input  logic [31:0]                  mv_shift,
  input  logic [NUM_CAND*2*MV_W-1:0]   mv_cand,
  input  logic [3:0]                   num_cand,
  input  logic [63:0]                  lambda_sqrt_integer_int64,
  input  logic [FRAC_W-1:0]            lambda_sqrt_decimal_int64,
  output logic [63:0]                  bitcost,
  output logic                         bitcost_ap_vld,
  output logic [2:0]                   best_idx,
  output logic [63:0]                  mvd_cost_int64,
  output logic                         mvd_cost_int64_ap_vld
);

  localparam int IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_MULT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [31:0]     xs_q, ys_q;
  logic [3:0]             n_q, n_clamp;
  logic [63:0]            lam_q;
  logic signed [MV_W-1:0] cand_x_q [NUM_CAND];
  logic signed [MV_W-1:0] cand_y_q [NUM_CAND];
  logic [IDX_W-1:0]       idx_q, min_idx_q;
  logic [7:0]             min_total_q, total;
  logic signed [32:0]     dx, dy;
  logic                   is_last, scan_end;
  logic                   unused_bits;

  assign unused_bits = ^{mv_shift[31:5], lambda_sqrt_decimal_int64[FRAC_W-2:0]};

  // Exp-Golomb code length: 2*floor(log2(k+1)) + 1 with k the signed-to-unsigned mapping of d.
  function automatic logic [6:0] eg_len(input logic signed [32:0] d);
    logic signed [34:0] d2;
    logic [34:0]        kp1;
    logic [5:0]         msb;
    d2 = {d[32], d, 1'b0};
    if (!d[32] && (d != '0)) kp1 = d2;
    else                     kp1 = 35'd1 - d2;
    msb = '0;
    for (int i = 0; i < 35; i++)
      if (kp1[i]) msb = 6'(i);
    return {msb, 1'b1};
  endfunction

  // Truncated-unary index cost: the last candidate drops the terminating bit.
  function automatic logic [3:0] idx_cost(input logic [3:0] i, input logic [3:0] n);
    if (n == 4'd1)            return 4'd0;
    else if (i < n - 4'd1)    return i + 4'd1;
    else                      return i;
  endfunction

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    n_clamp = num_cand;
    if (num_cand == 4'd0)                 n_clamp = 4'd1;
    else if (num_cand > 4'(NUM_CAND))     n_clamp = 4'(NUM_CAND);
  end

  always_comb begin
    dx      = {xs_q[31], xs_q} - {{(33-MV_W){cand_x_q[idx_q][MV_W-1]}}, cand_x_q[idx_q]};
    dy      = {ys_q[31], ys_q} - {{(33-MV_W){cand_y_q[idx_q][MV_W-1]}}, cand_y_q[idx_q]};
    total   = 8'(eg_len(dx)) + 8'(eg_len(dy)) + 8'(idx_cost(4'(idx_q), n_q));
    is_last = (4'(idx_q) == n_q - 4'd1);
  end

`ifdef ZERO_MVD_EARLY_EXIT_EN
  // A later candidate carries a higher index cost, so it can never strictly beat an exact match.
  assign scan_end = is_last || ((dx == '0) && (dy == '0));
`else
  assign scan_end = is_last;
`endif

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d               = state_q;
    ap_idle               = 1'b0;
    ap_done               = 1'b0;
    case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_d = S_SCAN;
      end
      S_SCAN:  if (scan_end) state_d = S_MULT;
      S_MULT:  state_d = S_DONE;
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ap_ready              = ap_done;
  assign bitcost_ap_vld        = ap_done;
  assign mvd_cost_int64_ap_vld = ap_done;

  // NOTE: operand and scan registers are always loaded before use, so they carry no reset.
  always_ff @(posedge ap_clk) begin
    if (state_q == S_IDLE && ap_start) begin
      xs_q  <= x << mv_shift[4:0];
      ys_q  <= y << mv_shift[4:0];
      n_q   <= n_clamp;
      lam_q <= lambda_sqrt_integer_int64 + 64'(lambda_sqrt_decimal_int64[FRAC_W-1]);
      idx_q <= '0;
      for (int i = 0; i < NUM_CAND; i++) begin
        cand_x_q[i] <= mv_cand[(2*i)*MV_W +: MV_W];
        cand_y_q[i] <= mv_cand[(2*i+1)*MV_W +: MV_W];
      end
    end else if (state_q == S_SCAN) begin
      idx_q <= idx_q + IDX_W'(1);
      // Strict less-than keeps the lower index on ties.
      if (idx_q == '0 || total < min_total_q) begin
        min_total_q <= total;
        min_idx_q   <= idx_q;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      bitcost        <= '0;
      best_idx       <= '0;
      mvd_cost_int64 <= '0;
    end else if (state_q == S_MULT) begin
      bitcost        <= 64'(min_total_q);
      best_idx       <= 3'(min_idx_q);
      mvd_cost_int64 <= 64'(min_total_q) * lam_q;
    end
  end

endmodule

// File: tb/tb_calc_mvd_cost_multi.sv
// Self-checking bench for calc_mvd_cost_multi: vector table driven through a scoreboard plus reset/handshake corners.
// Latency expectations follow ZERO_MVD_EARLY_EXIT_EN when it is defined.
module tb_calc_mvd_cost_multi;

  logic         ap_clk = 1'b0;
  logic         ap_rst, ap_start;
  logic         ap_done, ap_idle, ap_ready;
  logic [31:0]  x, y, mv_shift;
  logic [127:0] mv_cand;
  logic [3:0]   num_cand;
  logic [63:0]  lam_int;
  logic [63:0]  lam_dec;
  logic [63:0]  bitcost, mvd_cost_int64;
  logic         bitcost_ap_vld, mvd_cost_int64_ap_vld;
  logic [2:0]   best_idx;

  calc_mvd_cost_multi dut (
    .ap_clk                    (ap_clk),
    .ap_rst                    (ap_rst),
    .ap_start                  (ap_start),
    .ap_done                   (ap_done),
    .ap_idle                   (ap_idle),
    .ap_ready                  (ap_ready),
    .x                         (x),
    .y                         (y),
    .mv_shift                  (mv_shift),
    .mv_cand                   (mv_cand),
    .num_cand                  (num_cand),
    .lambda_sqrt_integer_int64 (lam_int),
    .lambda_sqrt_decimal_int64 (lam_dec),
    .bitcost                   (bitcost),
    .bitcost_ap_vld            (bitcost_ap_vld),
    .best_idx                  (best_idx),
    .mvd_cost_int64            (mvd_cost_int64),
    .mvd_cost_int64_ap_vld     (mvd_cost_int64_ap_vld)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0]  x, y, sh;
    logic [127:0] cands;
    logic [3:0]   nc;
    logic [63:0]  li;
    logic         dmsb;
    logic [63:0]  e_bits;
    logic [2:0]   e_idx;
    logic [63:0]  e_cost;
    int           lat_full, lat_early;
  } vec_t;

  typedef struct {
    logic [63:0] bits;
    logic [2:0]  idx;
    logic [63:0] cost;
    int          lat;
    int          start;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  function automatic logic [127:0] mk(int x0, int y0, int x1, int y1, int x2, int y2, int x3, int y3);
    return {16'(y3), 16'(x3), 16'(y2), 16'(x2), 16'(y1), 16'(x1), 16'(y0), 16'(x0)};
  endfunction

  // Scoreboard consumer: every ap_done pops one expected result.
  always @(negedge ap_clk) begin
    if (ap_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bitcost",   bitcost,         e.bits);
        check("best_idx",  64'(best_idx),   64'(e.idx));
        check("mvd_cost",  mvd_cost_int64,  e.cost);
        check("latency",   64'(cyc - e.start), 64'(e.lat));
        check("bc_vld",    64'(bitcost_ap_vld), 64'd1);
        check("cost_vld",  64'(mvd_cost_int64_ap_vld), 64'd1);
        check("ap_ready",  64'(ap_ready),   64'd1);
        check("idle_busy", 64'(ap_idle),    64'd0);
      end
    end
  end

  task automatic run_op(input vec_t v, input bit hold_start);
    exp_t e;
    @(negedge ap_clk);
    x        = v.x;
    y        = v.y;
    mv_shift = v.sh;
    mv_cand  = v.cands;
    num_cand = v.nc;
    lam_int  = v.li;
    lam_dec  = {v.dmsb, 31'($urandom), 32'($urandom)};
    ap_start = 1'b1;
    e.bits   = v.e_bits;
    e.idx    = v.e_idx;
    e.cost   = v.e_cost;
`ifdef ZERO_MVD_EARLY_EXIT_EN
    e.lat    = v.lat_early;
`else
    e.lat    = v.lat_full;
`endif
    e.start  = cyc;
    sb.push_back(e);
    @(negedge ap_clk);
    ap_start = hold_start;
    // Inputs after the latch edge must not matter.
    x        = $urandom;
    y        = $urandom;
    mv_shift = $urandom;
    mv_cand  = {$urandom, $urandom, $urandom, $urandom};
    num_cand = 4'($urandom);
    lam_int  = {$urandom, $urandom};
    for (int i = 0; i < 30; i++) begin
      #1;
      if (sb.size() == 0) break;
      @(negedge ap_clk);
    end
    ap_start = 1'b0;
    check("done_seen", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge ap_clk);
    check("done_pulse", 64'(ap_done), 64'd0);
    check("idle_after", 64'(ap_idle), 64'd1);
    check("hold_bits",  bitcost,      v.e_bits);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //         x            y             sh            cands                              nc    li                     d  bits idx cost  full early
    vecs[0] = '{32'd4,      32'd0,        32'd0,        mk(4,0, 3,0, 0,0, 0,0),            4'd2, 64'd10,                1, 3,   0,  33,   4, 3};
    vecs[1] = '{32'd4,      32'd0,        32'd0,        mk(5,0, 3,0, 0,0, 0,0),            4'd2, 64'd1,                 0, 5,   0,  5,    4, 4};
    vecs[2] = '{32'd1,      32'hFFFFFFFF, 32'd2,        mk(0,0, 0,0, 4,-4, 0,0),           4'd4, 64'd3,                 0, 5,   2,  15,   6, 5};
    vecs[3] = '{32'd0,      32'd0,        32'd0,        mk(0,0, 9,9, 9,9, 9,9),            4'd0, 64'd7,                 1, 2,   0,  16,   3, 3};
    vecs[4] = '{32'd0,      32'd0,        32'd0,        mk(0,0, 0,0, 0,0, 0,0),            4'd1, 64'h8000000000000000,  0, 2,   0,  0,    3, 3};
    vecs[5] = '{32'd0,      32'd0,        32'd0,        mk(1,0, 0,2, -1,-1, 0,0),          4'd9, 64'd100,               1, 5,   0,  505,  6, 6};
    vecs[6] = '{32'd100,    32'd0,        32'd0,        mk(0,0, 100,50, 99,0, -100,0),     4'd4, 64'd5,                 0, 7,   2,  35,   6, 6};
    vecs[7] = '{32'd1,      32'd0,        32'hFFFFFFFF, mk(0,0, 0,0, 0,0, 0,0),            4'd1, 64'd1,                 0, 66,  0,  66,   3, 3};

    ap_rst = 1'b1; ap_start = 1'b0;
    x = '0; y = '0; mv_shift = '0; mv_cand = '0; num_cand = '0; lam_int = '0; lam_dec = '0;
    repeat (3) @(negedge ap_clk);
    check("rst_idle",     64'(ap_idle),  64'd1);
    check("rst_done",     64'(ap_done),  64'd0);
    check("rst_ready",    64'(ap_ready), 64'd0);
    check("rst_vld",      64'(bitcost_ap_vld | mvd_cost_int64_ap_vld), 64'd0);
    check("rst_bitcost",  bitcost,        64'd0);
    check("rst_best_idx", 64'(best_idx),  64'd0);
    check("rst_mvd_cost", mvd_cost_int64, 64'd0);
    ap_rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(vecs[i], 1'b0);

    // Reset during the second SCAN cycle aborts without ap_done and clears the outputs.
    @(negedge ap_clk);
    x = vecs[2].x; y = vecs[2].y; mv_shift = vecs[2].sh; mv_cand = vecs[2].cands;
    num_cand = vecs[2].nc; lam_int = vecs[2].li; ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("abort_idle",     64'(ap_idle),   64'd1);
    check("abort_done",     64'(ap_done),   64'd0);
    check("abort_bitcost",  bitcost,        64'd0);
    check("abort_best_idx", 64'(best_idx),  64'd0);
    check("abort_mvd_cost", mvd_cost_int64, 64'd0);
    ap_rst = 1'b0;
    repeat (8) @(negedge ap_clk);
    run_op(vecs[0], 1'b0);

    // ap_start held high through SCAN and MULT must not restart; lambda 2^63 * 2 wraps to 0.
    run_op(vecs[4], 1'b1);
    repeat (8) @(negedge ap_clk);
    check("no_restart_idle", 64'(ap_idle), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
